// File: rtl/stdp_pkg.sv
// Shared types, default parameter values and weight clamp for the STDP learning block.
package stdp_pkg;

  typedef enum logic [0:0] {StIdle, StScan} stdp_state_e;

  localparam int unsigned DefNumPre   = 5;
  localparam int unsigned DefTw       = 8;
  localparam int unsigned DefWw       = 8;
  localparam int unsigned DefWin      = 16;
  localparam int unsigned DefLtpShift = 0;
  localparam int unsigned DefLtdShift = 0;
  localparam int unsigned DefWInit    = 128;

  function automatic int stdp_clamp(input int value, input int hi);
    if (value < 0) begin
      return 0;
    end else if (value > hi) begin
      return hi;
    end
    return value;
  endfunction

endpackage

// File: rtl/stdp_timer.sv
// Spike timer: cleared by a spike, otherwise counts up and holds at all-ones.
module stdp_timer #(
  parameter int unsigned TW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          spike,
  output logic [TW-1:0] count
);

  logic [TW-1:0] count_q;

  // Reset to saturation so nothing looks like a recent spike.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '1;
    end else if (spike) begin
      count_q <= '0;
    end else if (count_q != '1) begin
      count_q <= count_q + TW'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/stdp_learn.sv
// Pair-based STDP weight learning: serial LTP scan on post spikes, immediate LTD on pre spikes.
// Define STDP_LTD_EN to build the LTD path; without it learning is LTP-only.
module stdp_learn
  import stdp_pkg::*;
#(
  parameter int unsigned NUM_PRE   = DefNumPre,
  parameter int unsigned TW        = DefTw,
  parameter int unsigned WW        = DefWw,
  parameter int unsigned WIN       = DefWin,
  parameter int unsigned LTP_SHIFT = DefLtpShift,
  parameter int unsigned LTD_SHIFT = DefLtdShift,
  parameter int unsigned W_INIT    = DefWInit,
  localparam int unsigned SelW     = (NUM_PRE > 1) ? $clog2(NUM_PRE) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_PRE-1:0] pre_spike,
  input  logic               post_spike,
  input  logic [SelW-1:0]    sel,
  output logic [WW-1:0]      weight_out,
  output logic [TW-1:0]      dt_out,
  output logic               busy,
  output logic               update_done
);

  localparam int unsigned SumW = WW + 2;
  localparam int WMax = (1 << WW) - 1;
  localparam logic [SelW-1:0] LastIdx = SelW'(NUM_PRE - 1);

  logic [TW-1:0] pre_cnt [NUM_PRE];
  logic [TW-1:0] post_cnt;
  logic [TW-1:0] pre_dt  [NUM_PRE];
  logic [TW-1:0] post_dt;

  for (genvar g = 0; g < NUM_PRE; g++) begin : g_pre_timer
    stdp_timer #(.TW(TW)) u_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .spike (pre_spike[g]),
      .count (pre_cnt[g])
    );
  end

  stdp_timer #(.TW(TW)) u_post_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .spike (post_spike),
    .count (post_cnt)
  );

  function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] c);
    return (c == '1) ? c : c + TW'(1);
  endfunction

  // Timers hold the count as of the previous edge; +1 gives cycles elapsed up to this edge.
  always_comb begin
    post_dt = sat_inc(post_cnt);
    for (int i = 0; i < NUM_PRE; i++) begin
      pre_dt[i] = pre_spike[i] ? '0 : sat_inc(pre_cnt[i]);
    end
  end

  stdp_state_e     state_q;
  logic [SelW-1:0] idx_q;
  logic [TW-1:0]   snap_q [NUM_PRE];
  logic            busy_q;
  logic            done_q;

  // A post spike always (re)starts the scan, discarding any write pending for idx_q.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < NUM_PRE; i++) begin
        snap_q[i] <= '1;
      end
    end else begin
      done_q <= 1'b0;
      if (post_spike) begin
        state_q <= StScan;
        idx_q   <= '0;
        busy_q  <= 1'b1;
        for (int i = 0; i < NUM_PRE; i++) begin
          snap_q[i] <= pre_dt[i];
        end
      end else if (state_q == StScan) begin
        if (idx_q == LastIdx) begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end else begin
          idx_q <= idx_q + SelW'(1);
        end
      end
    end
  end

  logic [WW-1:0]          w_q       [NUM_PRE];
  logic [WW-1:0]          w_d       [NUM_PRE];
  logic signed [SumW-1:0] ltp_delta [NUM_PRE];
  logic signed [SumW-1:0] ltd_delta [NUM_PRE];
  logic signed [SumW-1:0] w_sum     [NUM_PRE];

  // LTP and LTD deltas for one channel are merged into a single clamped write.
  always_comb begin
    for (int i = 0; i < NUM_PRE; i++) begin
      ltp_delta[i] = '0;
      if (state_q == StScan && !post_spike && idx_q == SelW'(i) && snap_q[i] < TW'(WIN)) begin
        ltp_delta[i] = SumW'((WIN - 32'(snap_q[i])) >> LTP_SHIFT);
      end
`ifdef STDP_LTD_EN
      ltd_delta[i] = '0;
      if (pre_spike[i] && !post_spike && post_dt < TW'(WIN)) begin
        ltd_delta[i] = SumW'((WIN - 32'(post_dt)) >> LTD_SHIFT);
      end
`else
      ltd_delta[i] = '0;
`endif
      w_sum[i] = $signed({2'b00, w_q[i]}) + ltp_delta[i] - ltd_delta[i];
      w_d[i]   = WW'(stdp_clamp(int'(w_sum[i]), WMax));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PRE; i++) begin
        w_q[i] <= WW'(W_INIT);
      end
    end else begin
      for (int i = 0; i < NUM_PRE; i++) begin
        w_q[i] <= w_d[i];
      end
    end
  end

  logic [WW-1:0] weight_out_q;
  logic [TW-1:0] dt_out_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      weight_out_q <= '0;
      dt_out_q     <= '0;
    end else if (32'(sel) < NUM_PRE) begin
      weight_out_q <= w_q[sel];
      dt_out_q     <= pre_cnt[sel];
    end else begin
      weight_out_q <= '0;
      dt_out_q     <= '0;
    end
  end

  assign weight_out  = weight_out_q;
  assign dt_out      = dt_out_q;
  assign busy        = busy_q;
  assign update_done = done_q;

endmodule

// File: tb/tb_stdp_learn.sv
// Scoreboard bench for stdp_learn against an event-time reference model.
module tb_stdp_learn;

  localparam int NP   = 5;
  localparam int WIN  = 16;
  localparam int TMAX = 255;
  localparam int NEVER = -100000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] pre;
  logic       post;
  logic [2:0] sel;
  logic [7:0] wout;
  logic [7:0] dtout;
  logic       busy;
  logic       done;

  always #5 clk = ~clk;

  stdp_learn u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pre_spike   (pre),
    .post_spike  (post),
    .sel         (sel),
    .weight_out  (wout),
    .dt_out      (dtout),
    .busy        (busy),
    .update_done (done)
  );

  logic       rst_c_n;
  logic [4:0] pre_h, pre_l;
  logic       post_h, post_l;
  logic [7:0] wout_h, wout_l, dt_h, dt_l;
  logic       busy_h, busy_l, done_h, done_l;

  stdp_learn #(.W_INIT(250)) u_hi (
    .clk         (clk),
    .rst_n       (rst_c_n),
    .pre_spike   (pre_h),
    .post_spike  (post_h),
    .sel         (3'd0),
    .weight_out  (wout_h),
    .dt_out      (dt_h),
    .busy        (busy_h),
    .update_done (done_h)
  );

  stdp_learn #(.W_INIT(5)) u_lo (
    .clk         (clk),
    .rst_n       (rst_c_n),
    .pre_spike   (pre_l),
    .post_spike  (post_l),
    .sel         (3'd0),
    .weight_out  (wout_l),
    .dt_out      (dt_l),
    .busy        (busy_l),
    .update_done (done_l)
  );

  typedef struct {
    int wout;
    int dt;
    int busy;
    int done;
  } exp_t;

  exp_t sb_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  function automatic void check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endfunction

  // Reference model: events are remembered by the edge index at which they happened.
  int w [NP];
  int last_pre [NP];
  int last_post;
  int scan_start;
  int snap [NP];
  bit scanning;
  int e = 0;

  function automatic int sat(input int v);
    return (v > TMAX) ? TMAX : v;
  endfunction

  function automatic int clamp8(input int v);
    return (v < 0) ? 0 : ((v > 255) ? 255 : v);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NP; i++) begin
      w[i] = 128;
      last_pre[i] = NEVER;
    end
    last_post = NEVER;
    scanning = 1'b0;
  endfunction

  task automatic step(input logic [4:0] p, input logic po, input logic [2:0] s, input logic r);
    exp_t ex;
    int   delta [NP];
    int   dpost;
    int   ch;
    pre   = p;
    post  = po;
    sel   = s;
    rst_n = r;
    if (!r) begin
      ex = '{0, 0, 0, 0};
      model_reset();
    end else begin
      ex.wout = (s < NP) ? w[s] : 0;
      ex.dt   = (s < NP) ? sat(e - 1 - last_pre[s]) : 0;
      ex.done = 0;
      for (int i = 0; i < NP; i++) delta[i] = 0;
      dpost = sat(e - last_post);
      if (po) begin
        scanning   = 1'b1;
        scan_start = e;
        for (int i = 0; i < NP; i++) snap[i] = p[i] ? 0 : sat(e - last_pre[i]);
      end else if (scanning) begin
        ch = e - scan_start - 1;
        if (snap[ch] < WIN) delta[ch] += WIN - snap[ch];
        if (ch == NP - 1) begin
          scanning = 1'b0;
          ex.done  = 1;
        end
      end
`ifdef STDP_LTD_EN
      for (int i = 0; i < NP; i++) begin
        if (p[i] && !po && dpost < WIN) delta[i] -= WIN - dpost;
      end
`endif
      for (int i = 0; i < NP; i++) begin
        w[i] = clamp8(w[i] + delta[i]);
        if (p[i]) last_pre[i] = e;
      end
      if (po) last_post = e;
      ex.busy = scanning ? 1 : 0;
    end
    @(posedge clk);
    #1;
    sb_q.push_back(ex);
    e++;
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        x = sb_q.pop_front();
        check("weight_out", int'(wout), x.wout);
        check("dt_out", int'(dtout), x.dt);
        check("busy", int'(busy), x.busy);
        check("update_done", int'(done), x.done);
      end
    end
  end

  task automatic idle(input int n, input logic [2:0] s);
    for (int i = 0; i < n; i++) step(5'd0, 1'b0, s, 1'b1);
  endtask

  initial begin : stim
    int lo_req;
    rst_c_n = 1'b0;
    pre_h = '0; pre_l = '0; post_h = 1'b0; post_l = 1'b0;
    model_reset();
    step(5'd0, 1'b0, 3'd0, 1'b0);
    step(5'd0, 1'b0, 3'd0, 1'b0);
    for (int s = 0; s < 8; s++) step(5'd0, 1'b0, 3'(s), 1'b1);
    // Pre on channel 2, post five cycles later.
    step(5'b00100, 1'b0, 3'd2, 1'b1);
    idle(4, 3'd2);
    step(5'd0, 1'b1, 3'd2, 1'b1);
    idle(8, 3'd2);
    // Post then pre on channel 1 three cycles later.
    step(5'd0, 1'b1, 3'd1, 1'b1);
    idle(2, 3'd1);
    step(5'b00010, 1'b0, 3'd1, 1'b1);
    idle(8, 3'd1);
    // Restarted scan.
    step(5'b01001, 1'b1, 3'd0, 1'b1);
    idle(1, 3'd3);
    step(5'd0, 1'b1, 3'd3, 1'b1);
    idle(8, 3'd0);
    // Reset mid-scan.
    step(5'b10000, 1'b0, 3'd4, 1'b1);
    step(5'd0, 1'b1, 3'd4, 1'b1);
    idle(2, 3'd4);
    step(5'd0, 1'b0, 3'd4, 1'b0);
    for (int s = 0; s < 8; s++) step(5'd0, 1'b0, 3'(s), 1'b1);
    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      logic [4:0] p;
      for (int i = 0; i < NP; i++) p[i] = ($urandom_range(0, 7) == 0);
      step(p, $urandom_range(0, 11) == 0, 3'($urandom_range(0, 7)),
           $urandom_range(0, 299) != 0);
    end
    for (int s = 0; s < 8; s++) step(5'd0, 1'b0, 3'(s), 1'b1);
    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 0);

    // Clamp instances: full LTP from 250, and LTD below zero from 5.
    @(posedge clk); #1;
    rst_c_n = 1'b1;
    @(posedge clk); #1;
    check("hi_reset_weight", int'(wout_h), 250);
    check("lo_reset_weight", int'(wout_l), 5);
    pre_h = 5'b00001; post_h = 1'b1; post_l = 1'b1;
    @(posedge clk); #1;
    pre_h = '0; post_h = 1'b0; post_l = 1'b0; pre_l = 5'b00001;
    @(posedge clk); #1;
    pre_l = '0;
    repeat (8) @(posedge clk);
    #1;
`ifdef STDP_LTD_EN
    lo_req = 0;
`else
    lo_req = 5;
`endif
    check("hi_clamp_weight", int'(wout_h), 255);
    check("lo_clamp_weight", int'(wout_l), lo_req);
    check("hi_busy_idle", int'(busy_h), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
